// File: rtl/pipe_latch_elastic.sv
// -----------------------------------------------------------------------------
// pipe_latch_elastic
//
// Elastic pipeline latch placed between two pipeline stages. It behaves like
// the classic stage register (driven by a 2-bit stage-control code) but holds
// up to DEPTH results in a small circular buffer. This lets the producing
// stage keep going for a few cycles while the consuming stage is busy.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active low (0 = reset)
//   ctr[1:0]   stage control: 00 NORMAL, 01 STALL, 10 FLUSH, 11 DRAIN
//   in_valid   upstream offers in_data this cycle
//   in_data    payload, N bits
//   in_ready   latch accepts in_data this cycle
//   out_valid  head entry is valid
//   out_data   head entry payload (all zeros when empty)
//   out_ready  downstream consumes the head this cycle
//   count      number of occupied entries, 0..DEPTH
//
// Notes
//   - One cycle of latency: there is no bypass from in_data to out_data.
//   - in_ready depends only on registered state and ctr. It never depends
//     on out_ready, so no combinational ready path runs through the block.
// -----------------------------------------------------------------------------
module pipe_latch_elastic #(
   parameter int N     = 64,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    ctr,
   input  logic          in_valid,
   input  logic [N-1:0]  in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [N-1:0]  out_data,
   input  logic          out_ready,
   output logic [CW-1:0] count
);

   // Pointer width. It is kept at least 1 bit wide so that DEPTH=1 still
   // gives a legal (constant-zero) pointer.
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      CTR_NORMAL = 2'b00,
      CTR_STALL  = 2'b01,
      CTR_FLUSH  = 2'b10,
      CTR_DRAIN  = 2'b11
   } ctr_e;

   ctr_e          w_mode;
   logic [N-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wp;
   logic [PW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic [PW-1:0] w_wp_inc;
   logic [PW-1:0] w_rp_inc;
   logic [CW-1:0] w_cnt_next;
   logic          w_full;
   logic          w_empty;
   logic          w_push;
   logic          w_pop;

   assign w_mode  = ctr_e'(ctr);
   assign w_full  = (r_cnt == CW'(DEPTH));
   assign w_empty = (r_cnt == '0);

   // Explicit wrap from DEPTH-1 to 0. This keeps non-power-of-two depths
   // correct, where a plain binary rollover would step past the last entry.
   assign w_wp_inc = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
   assign w_rp_inc = (r_rp == PW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;

   // The rst term holds in_ready low during reset, before any clock edge.
   assign in_ready  = (w_mode == CTR_NORMAL) && !w_full && rst;
   assign out_valid = !w_empty;
   assign out_data  = w_empty ? '0 : r_mem[r_rp];
   assign count     = r_cnt;

   assign w_push = in_valid && in_ready;
   // FLUSH and STALL are excluded here. A same-cycle out_ready under FLUSH
   // therefore never counts as a consumed entry.
   assign w_pop  = out_valid && out_ready &&
                   ((w_mode == CTR_NORMAL) || (w_mode == CTR_DRAIN));

   always_comb begin
      w_cnt_next = r_cnt;
      if (w_push && !w_pop) begin
         w_cnt_next = r_cnt + 1'b1;
      end else if (!w_push && w_pop) begin
         w_cnt_next = r_cnt - 1'b1;
      end
   end

   // Payload storage has no reset. Stale contents are never visible, because
   // out_data is forced to zero whenever the buffer is empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wp] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wp  <= '0;
         r_rp  <= '0;
         r_cnt <= '0;
      end else if (w_mode == CTR_FLUSH) begin
         // Drop everything held. Aligning rp to wp (rather than zeroing both)
         // leaves the write pointer undisturbed.
         r_cnt <= '0;
         r_rp  <= r_wp;
      end else begin
         if (w_push) begin
            r_wp <= w_wp_inc;
         end
         if (w_pop) begin
            r_rp <= w_rp_inc;
         end
         r_cnt <= w_cnt_next;
      end
   end

endmodule

// File: tb/tb_pipe_latch_elastic.sv
module tb_pipe_latch_elastic;

   localparam int N     = 8;
   localparam int DEPTH = 3;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk;
   logic          rst;
   logic [1:0]    ctr;
   logic          in_valid;
   logic [N-1:0]  in_data;
   logic          in_ready;
   logic          out_valid;
   logic [N-1:0]  out_data;
   logic          out_ready;
   logic [CW-1:0] count;

   int total = 0;
   int bad   = 0;

   // Expected payloads in order; the driver pushes, the monitor pops.
   logic [N-1:0] exp_q[$];

   pipe_latch_elastic #(.N(N), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .ctr       (ctr),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: sample mid-cycle, while the inputs are stable for the coming edge.
   always @(negedge clk) begin
      if (rst) begin
         if (out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL data_unexpected: got out_data=%02h, required no valid entry", out_data);
            end else begin
               if (out_data !== exp_q[0]) begin
                  bad++;
                  $display("FAIL data_order: got out_data=%02h, required %02h", out_data, exp_q[0]);
               end else begin
                  $display("data ok: %02h (ctr=%b ordy=%b)", out_data, ctr, out_ready);
               end
               if (out_ready && (ctr == 2'b00 || ctr == 2'b11))
                  void'(exp_q.pop_front());
            end
         end else begin
            total++;
            if (out_data !== '0) begin
               bad++;
               $display("FAIL data_empty_zero: got out_data=%02h, required 00", out_data);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      total++;
      if (got !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, got, req);
      end
   endtask

   // Drive one cycle of stimulus from just after a rising edge. The e_* arguments
   // are the hand-computed values expected during this cycle, before the next edge.
   task automatic cycle(input logic iv, input logic [N-1:0] d, input logic ordy,
                        input logic [1:0] c, input logic e_rdy,
                        input logic [CW-1:0] e_cnt, input logic e_ov);
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      ctr       = c;
      @(negedge clk);
      chk("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
      chk("count", {{(32-CW){1'b0}}, count}, {{(32-CW){1'b0}}, e_cnt});
      chk("out_valid", {31'd0, out_valid}, {31'd0, e_ov});
      $display("cyc: ctr=%b iv=%b d=%02h ordy=%b -> rdy=%b cnt=%0d ov=%b od=%02h",
               c, iv, d, ordy, in_ready, count, out_valid, out_data);
      if (iv && e_rdy) exp_q.push_back(d);
      @(posedge clk);
      #1;
      if (c == 2'b10) exp_q.delete();
   endtask

   initial begin
      rst = 1'b0; ctr = 2'b00; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #2;
      chk("reset_ready", {31'd0, in_ready}, 32'd0);
      chk("reset_count", {{(32-CW){1'b0}}, count}, 32'd0);
      chk("reset_valid", {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Fill to full, then drain. The overflow attempt (A4) must not be stored.
      cycle(1, 8'hA1, 0, 2'b00, 1, 0, 0);
      cycle(1, 8'hA2, 0, 2'b00, 1, 1, 1);
      cycle(1, 8'hA3, 0, 2'b00, 1, 2, 1);
      cycle(1, 8'hA4, 0, 2'b00, 0, 3, 1);
      cycle(0, 8'h00, 1, 2'b00, 0, 3, 1);
      cycle(0, 8'h00, 1, 2'b00, 1, 2, 1);
      cycle(0, 8'h00, 1, 2'b00, 1, 1, 1);
      cycle(0, 8'h00, 1, 2'b00, 1, 0, 0);

      // Fill again, then push and pop together; the pointers wrap past index 2.
      cycle(1, 8'hB1, 0, 2'b00, 1, 0, 0);
      cycle(1, 8'hB2, 0, 2'b00, 1, 1, 1);
      cycle(1, 8'hB3, 0, 2'b00, 1, 2, 1);
      cycle(0, 8'h00, 1, 2'b00, 0, 3, 1);
      cycle(1, 8'h55, 1, 2'b00, 1, 2, 1);
      cycle(1, 8'h66, 1, 2'b00, 1, 2, 1);
      cycle(0, 8'h00, 0, 2'b00, 1, 2, 1);
      cycle(0, 8'h00, 1, 2'b00, 1, 2, 1);
      cycle(1, 8'h3C, 1, 2'b00, 1, 1, 1);

      // STALL for four cycles with head 3C.
      for (int i = 0; i < 4; i++) cycle(1, 8'h77, 1, 2'b01, 0, 1, 1);
      cycle(1, 8'hC1, 0, 2'b00, 1, 1, 1);

      // FLUSH while a handshake is offered on both sides.
      cycle(1, 8'h99, 1, 2'b10, 0, 2, 1);
      cycle(1, 8'hD1, 0, 2'b00, 1, 0, 0);
      cycle(1, 8'hD2, 0, 2'b00, 1, 1, 1);

      // DRAIN: pops continue, pushes are refused.
      cycle(1, 8'hEE, 1, 2'b11, 0, 2, 1);
      cycle(1, 8'hEE, 1, 2'b11, 0, 1, 1);
      cycle(0, 8'h00, 0, 2'b11, 0, 0, 0);
      cycle(0, 8'h00, 0, 2'b00, 1, 0, 0);

      // Asynchronous reset applied mid-stream with two entries held.
      cycle(1, 8'hF1, 0, 2'b00, 1, 0, 0);
      cycle(1, 8'hF2, 0, 2'b00, 1, 1, 1);
      in_valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("async_rst_count", {{(32-CW){1'b0}}, count}, 32'd0);
      chk("async_rst_ready", {31'd0, in_ready}, 32'd0);
      $display("async reset: ov=%b cnt=%0d rdy=%b", out_valid, count, in_ready);
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
      cycle(0, 8'h00, 0, 2'b00, 1, 0, 0);
      cycle(1, 8'h5A, 0, 2'b00, 1, 0, 0);
      cycle(0, 8'h00, 1, 2'b00, 1, 1, 1);
      cycle(0, 8'h00, 0, 2'b00, 1, 0, 0);

      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL queue_drained: got %0d entries left, required 0", exp_q.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pipe_latch_elastic.md
Name: pipe_latch_elastic

Overview:
- Parametrised successor to the fixed-width pipeline latch used between pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Keeps the 2-bit stage-control interface.
- Adds valid/ready handshaking and a DEPTH-entry elastic FIFO, so a stage can absorb one or more results while the downstream stage is stalled (e.g. a busy execution unit or memory stage).
- Adds an occupancy count for the pipeline controller.

Parameters:
N, 64, payload width in bits (must be >= 1).
DEPTH, 2, number of buffer entries (>= 1; need not be a power of two).
CW, $clog2(DEPTH+1), width of the occupancy count (derived; do not override).

Ports:
clk  in  1  rising-edge clock.
rst  in  1  asynchronous reset, active-low (0 = reset).
ctr  in  2  stage control: 00 NORMAL, 01 STALL, 10 FLUSH, 11 DRAIN.
in_valid  in  1  upstream offers in_data this cycle.
in_data  in  N  payload.
in_ready  out  1  latch accepts in_data this cycle.
out_valid  out  1  head entry is valid.
out_data  out  N  head entry payload.
out_ready  in  1  downstream consumes the head this cycle.
count  out  CW  current number of occupied entries (0..DEPTH).

Behaviour:
- Storage: circular buffer of DEPTH entries, write pointer wp, read pointer rp, occupancy cnt.
  - Pointers increment mod DEPTH; they wrap explicitly from DEPTH-1 to 0, including for non-power-of-two DEPTH.
- Reset (rst=0, asynchronous): wp=rp=cnt=0 immediately, without waiting for a clock edge.
  - out_valid=0, out_data=0, count=0, in_ready=0 while rst=0.
  - Buffer contents need not be cleared.
- Combinational outputs:
  - out_valid = (cnt != 0).
  - out_data = mem[rp] when cnt != 0, else all zeros.
  - count = cnt.
  - in_ready = (ctr==00) && (cnt < DEPTH) && rst.
  - in_ready does not depend on out_ready (no combinational ready path through the block).
- Per-cycle events, evaluated at the rising edge:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready && (ctr==00 || ctr==11).
- NORMAL (00):
  - push writes mem[wp] and advances wp.
  - pop advances rp.
  - cnt += push - pop.
  - Push and pop may occur together; cnt is then unchanged.
- STALL (01):
  - no push, no pop; all state holds.
  - out_valid/out_data stay stable while the stall lasts.
- FLUSH (10):
  - at the edge, cnt=0 and rp=wp; in_data is discarded.
  - out_valid=0 from the cycle after the edge.
  - FLUSH takes priority over any concurrent handshake; the downstream must not treat a same-cycle out_ready as a consumed entry.
- DRAIN (11):
  - no push (in_ready=0); pop allowed.
  - Inserts bubbles upstream while the downstream empties the buffer.
- Latency: an entry pushed at edge k appears at out_valid/out_data after edge k, i.e. one cycle of latency.
  - No bypass from in_data to out_data in the same cycle.
- Ordering: strict FIFO; entries leave in push order.
- Full: cnt==DEPTH forces in_ready=0.
  - A pop in that cycle frees a slot for the next cycle only.
- Empty: cnt==0 forces out_valid=0; out_ready is ignored.
- in_valid while in_ready=0: nothing is stored. Upstream must hold its data.
- No overflow/underflow is reachable. count never exceeds DEPTH and never goes below 0.
- ctr values change only at clock edges (they are registered by the pipeline controller). The block treats ctr as sampled at the edge.
- DEPTH=1 degenerates to a classic enable/flush latch with a registered valid bit.

Test Plan:
- Reset: hold rst=0 mid-stream with cnt=2 -> out_valid=0, count=0, in_ready=0 immediately; after rst=1, in_ready=1 with ctr=00.
- Fill and drain, DEPTH=2, N=8, ctr=00, out_ready=0: push 0xA1, 0xA2 -> count=2, in_ready=0; then out_ready=1 -> outputs 0xA1 then 0xA2 on consecutive cycles, count 1 then 0, out_data=0 when empty.
- Simultaneous push/pop, DEPTH=3: with count=3, pop once -> count=2; next cycle push 0x55 while popping -> count stays 2, order preserved; pointers wrap past index 2 to 0 correctly.
- STALL: with count=1 and head 0x3C, hold ctr=01 for 4 cycles with in_valid=1 and out_ready=1 -> out_data=0x3C, count=1, in_ready=0 throughout.
- FLUSH with concurrent handshake: count=2, ctr=10, in_valid=1, out_ready=1 -> after the edge count=0, out_valid=0; the input is not stored.
- DRAIN: count=2, ctr=11, in_valid=1, out_ready=1 -> two pops, count 2 to 1 to 0, in_ready=0 throughout; returning to ctr=00 restores in_ready=1.
